// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Two-port (instruction / data) arbiter onto one shared memory
//                port. Ties alternate, every transaction is bounded by a
//                timeout, and all outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                      clk,
    input  logic                      reset_n,
    // instruction port (read only)
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    output logic                      i_ack,
    output logic                      i_err,
    // data port
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_ack,
    output logic                      d_err,
    // shared memory port
    output logic                      m_req,
    output logic                      m_we,
    output logic [ADDR_WIDTH-1:0]     m_addr,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic                      m_ack,
    // debug
    output logic [1:0]                grant
);

    localparam int          STRB_WIDTH = DATA_WIDTH / 8;
    // Counter value at which an unanswered transaction is given up.
    localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [15:0]             cnt, cnt_next;
    logic                    last_was_d, last_was_d_next;   // 1: data port won last
    logic                    pick_i, pick_d;
    logic                    done, timed_out;

    logic                    m_req_next, m_we_next;
    logic [ADDR_WIDTH-1:0]   m_addr_next;
    logic [DATA_WIDTH-1:0]   m_wdata_next;
    logic [STRB_WIDTH-1:0]   m_wstrb_next;
    logic [DATA_WIDTH-1:0]   i_rdata_next, d_rdata_next, cpl_rdata;
    logic                    i_ack_next, i_err_next, d_ack_next, d_err_next;
    logic [1:0]              grant_next;

    // Next-state and next-output computation; acks/errors/rdata default to
    // zero so completions are single-cycle pulses.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        last_was_d_next = last_was_d;
        m_req_next      = m_req;
        m_we_next       = m_we;
        m_addr_next     = m_addr;
        m_wdata_next    = m_wdata;
        m_wstrb_next    = m_wstrb;
        grant_next      = grant;
        i_rdata_next    = '0;
        d_rdata_next    = '0;
        i_ack_next      = 1'b0;
        i_err_next      = 1'b0;
        d_ack_next      = 1'b0;
        d_err_next      = 1'b0;
        pick_i          = 1'b0;
        pick_d          = 1'b0;
        done            = 1'b0;
        timed_out       = 1'b0;
        cpl_rdata       = '0;

        case (state)
            IDLE: begin
                // The cycle carrying an ack is a mandatory idle cycle: no grant
                // is made while a completion is still being presented.
                if (!i_ack && !d_ack) begin
                    pick_i = i_req && (!d_req || last_was_d);
                    pick_d = d_req && !pick_i;
                end
                if (pick_i) begin
                    state_next   = BUSY_I;
                    cnt_next     = '0;
                    m_req_next   = 1'b1;
                    m_we_next    = 1'b0;
                    m_addr_next  = i_addr;
                    m_wdata_next = '0;
                    m_wstrb_next = '0;
                    grant_next   = 2'b01;
                end else if (pick_d) begin
                    state_next   = BUSY_D;
                    cnt_next     = '0;
                    m_req_next   = 1'b1;
                    m_we_next    = d_we;
                    m_addr_next  = d_addr;
                    m_wdata_next = d_wdata;
                    m_wstrb_next = d_wstrb;
                    grant_next   = 2'b10;
                end
            end

            BUSY_I, BUSY_D: begin
                cnt_next = cnt + 16'd1;
                // A memory ack on the timeout cycle still counts as success.
                if (m_ack) begin
                    done      = 1'b1;
                    cpl_rdata = m_we ? '0 : m_rdata;
                end else if (cnt == CNT_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end
                if (done) begin
                    state_next      = IDLE;
                    m_req_next      = 1'b0;
                    grant_next      = 2'b00;
                    last_was_d_next = (state == BUSY_D);
                    if (state == BUSY_I) begin
                        i_ack_next   = 1'b1;
                        i_err_next   = timed_out;
                        i_rdata_next = cpl_rdata;
                    end else begin
                        d_ack_next   = 1'b1;
                        d_err_next   = timed_out;
                        d_rdata_next = cpl_rdata;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                m_req_next = 1'b0;
                grant_next = 2'b00;
            end
        endcase
    end

    // State and registered outputs; reset abandons any open transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_was_d <= 1'b1;   // instruction port wins the first tie
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            grant      <= 2'b00;
            i_rdata    <= '0;
            i_ack      <= 1'b0;
            i_err      <= 1'b0;
            d_rdata    <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_was_d <= last_was_d_next;
            m_req      <= m_req_next;
            m_we       <= m_we_next;
            m_addr     <= m_addr_next;
            m_wdata    <= m_wdata_next;
            m_wstrb    <= m_wstrb_next;
            grant      <= grant_next;
            i_rdata    <= i_rdata_next;
            i_ack      <= i_ack_next;
            i_err      <= i_err_next;
            d_rdata    <= d_rdata_next;
            d_ack      <= d_ack_next;
            d_err      <= d_err_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Self-checking bench for memory_arbiter; expected completions
//                are queued when requests are issued and popped on each ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack, i_err;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic [DW-1:0] d_rdata;
    logic          d_ack, d_err;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic [1:0]    grant;

    typedef struct {
        bit            is_d;
        logic [DW-1:0] rdata;
        bit            err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ack(m_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        m_rdata = '0; m_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_m_req: got %b want 0", m_req); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        checks++; if ({i_ack, i_err, d_ack, d_err} !== 4'b0) begin errors++; $display("FAIL rst_acks: got %b want 0000", {i_ack, i_err, d_ack, d_err}); end
        checks++; if ({m_addr, m_wdata, m_wstrb, m_we} !== '0) begin errors++; $display("FAIL rst_m_fields: got %h/%h/%h/%b want 0", m_addr, m_wdata, m_wstrb, m_we); end
        checks++; if ({i_rdata, d_rdata} !== '0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0", i_rdata, d_rdata); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_idle_after: m_req got %b want 0", m_req); end
    endtask

    task automatic test_ifetch();
        exp_t e;
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'h0000_0013;
        i_req = 1'b1; i_addr = 32'h8000_0000;
        @(negedge clk);
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL if_m_req: got %b want 1", m_req); end
        checks++; if (m_addr !== 32'h8000_0000) begin errors++; $display("FAIL if_m_addr: got %h want 80000000", m_addr); end
        checks++; if ({m_we, m_wstrb, m_wdata} !== '0) begin errors++; $display("FAIL if_m_cmd: got %b/%h/%h want 0", m_we, m_wstrb, m_wdata); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL if_grant: got %b want 01", grant); end
        sb.push_back('{is_d: 1'b0, rdata: 32'h0000_0013, err: 1'b0});
        @(negedge clk);
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0) begin
            errors++; $display("FAIL if_ack: got i=%b d=%b want i=1 d=0", i_ack, d_ack);
        end else begin
            e = sb.pop_front();
            checks++; if (i_rdata !== e.rdata) begin errors++; $display("FAIL if_rdata: got %h want %h", i_rdata, e.rdata); end
            checks++; if (i_err !== e.err) begin errors++; $display("FAIL if_err: got %b want %b", i_err, e.err); end
        end
        checks++; if (m_req !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL if_release: m_req=%b grant=%b want 0/00", m_req, grant); end
        i_req = 1'b0;
        @(negedge clk);
        checks++; if (i_ack !== 1'b0 || m_req !== 1'b0) begin errors++; $display("FAIL if_pulse: i_ack=%b m_req=%b want 0/0", i_ack, m_req); end
    endtask

    task automatic test_write();
        exp_t e;
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'h55AA_55AA;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || m_we !== 1'b1) begin errors++; $display("FAIL wr_m_req_we: got %b/%b want 1/1", m_req, m_we); end
        checks++; if (m_addr !== 32'h100) begin errors++; $display("FAIL wr_m_addr: got %h want 00000100", m_addr); end
        checks++; if (m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'hF) begin errors++; $display("FAIL wr_m_data: got %h/%h want deadbeef/f", m_wdata, m_wstrb); end
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b want 10", grant); end
        sb.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b0});
        @(negedge clk);
        checks++;
        if (d_ack !== 1'b1 || i_ack !== 1'b0) begin
            errors++; $display("FAIL wr_ack: got d=%b i=%b want d=1 i=0", d_ack, i_ack);
        end else begin
            e = sb.pop_front();
            checks++; if (d_rdata !== e.rdata) begin errors++; $display("FAIL wr_rdata: got %h want %h", d_rdata, e.rdata); end
            checks++; if (d_err !== e.err) begin errors++; $display("FAIL wr_err: got %b want %b", d_err, e.err); end
        end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   acks = 0;
        int   last_ack = -1;
        @(negedge clk);
        reset_n = 1'b0;
        m_ack = 1'b1; m_rdata = 32'hCAFE_0001;
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back('{is_d: (k % 2 == 1), rdata: 32'hCAFE_0001, err: 1'b0});
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c % 3 == 1) begin
                checks++;
                if (grant !== ((c % 6 == 1) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL b2b_grant c=%0d: got %b want %b", c, grant, (c % 6 == 1) ? 2'b01 : 2'b10);
                end
            end
            if (i_ack || d_ack) begin
                acks++;
                checks++;
                if (c != ((last_ack < 0) ? 2 : last_ack + 3)) begin
                    errors++; $display("FAIL b2b_spacing: ack at cycle %0d want %0d", c, (last_ack < 0) ? 2 : last_ack + 3);
                end
                last_ack = c;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_ack: cycle %0d got ack want none", c);
                end else begin
                    e = sb.pop_front();
                    if ({i_ack, d_ack} !== (e.is_d ? 2'b01 : 2'b10) ||
                        (e.is_d ? d_rdata : i_rdata) !== e.rdata) begin
                        errors++; $display("FAIL b2b_order cycle %0d: got i/d=%b%b rdata=%h want d=%b rdata=%h",
                                           c, i_ack, d_ack, e.is_d ? d_rdata : i_rdata, e.is_d, e.rdata);
                    end
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++; if (acks != 4) begin errors++; $display("FAIL b2b_count: got %0d acks want 4", acks); end
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        exp_t e;
        int   k = 0;
        bit   seen = 0;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'hFFFF_FFFF;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = '0; d_wstrb = '0;
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || grant !== 2'b10 || m_addr !== 32'h200) begin errors++; $display("FAIL to_issue: m_req=%b grant=%b addr=%h want 1/10/200", m_req, grant, m_addr); end
        sb.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b1});
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (d_ack) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL to_no_ack: got none after %0d cycles want ack at 8", k);
        end else begin
            checks++; if (k != TO) begin errors++; $display("FAIL to_latency: got %0d cycles want %0d", k, TO); end
            e = sb.pop_front();
            checks++; if (d_err !== e.err || d_rdata !== e.rdata) begin errors++; $display("FAIL to_result: got err=%b rdata=%h want err=%b rdata=%h", d_err, d_rdata, e.err, e.rdata); end
            checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL to_m_req: got %b want 0", m_req); end
        end
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (d_ack !== 1'b0 || m_req !== 1'b0) begin errors++; $display("FAIL to_after: d_ack=%b m_req=%b want 0/0", d_ack, m_req); end
        sb.delete();
    endtask

    task automatic test_mack_at_timeout();
        exp_t e;
        int   k = 0;
        bit   seen = 0;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = '0;
        i_req = 1'b1; i_addr = 32'h300;
        @(negedge clk);
        sb.push_back('{is_d: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (i_ack) seen = 1;
            else if (k == TO - 1) begin m_ack = 1'b1; m_rdata = 32'h1234_5678; end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL tie_no_ack: got none want ack at %0d", TO);
        end else begin
            e = sb.pop_front();
            checks++; if (k != TO || i_err !== e.err || i_rdata !== e.rdata) begin errors++; $display("FAIL tie_result: got k=%0d err=%b rdata=%h want k=%0d err=%b rdata=%h", k, i_err, i_rdata, TO, e.err, e.rdata); end
        end
        i_req = 1'b0; m_ack = 1'b0;
        @(negedge clk);
        sb.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   k = 0;
        int   stray = 0;
        bit   seen = 0;
        @(negedge clk);
        m_ack = 1'b0; m_rdata = 32'h0000_00AA;
        i_req = 1'b1; i_addr = 32'h40;
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL rm_issue: m_req=%b grant=%b want 1/01", m_req, grant); end
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (m_req !== 1'b0 || grant !== 2'b00 || m_addr !== '0) begin errors++; $display("FAIL rm_async: m_req=%b grant=%b addr=%h want 0/00/0", m_req, grant, m_addr); end
        i_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) m_ack = 1'b1;
            if (i_ack || d_ack || m_req) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rm_stray: got %0d active cycles want 0", stray); end
        m_ack = 1'b0; m_rdata = 32'h0BAD_F00D;
        i_req = 1'b1; i_addr = 32'h44;
        @(negedge clk);
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h44) begin errors++; $display("FAIL rm_reissue: m_req=%b addr=%h want 1/44", m_req, m_addr); end
        sb.push_back('{is_d: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (i_ack) seen = 1;
            else if (k == 5) m_ack = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rm_no_ack: got none want ack at 6");
        end else begin
            e = sb.pop_front();
            checks++; if (k != 6 || i_err !== e.err || i_rdata !== e.rdata) begin errors++; $display("FAIL rm_result: got k=%0d err=%b rdata=%h want k=6 err=%b rdata=%h", k, i_err, i_rdata, e.err, e.rdata); end
        end
        i_req = 1'b0; m_ack = 1'b0;
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_write();
        test_back_to_back();
        test_timeout();
        test_mack_at_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
